trace_capture_unit: RTL and testbench

//   Triggered on-chip trace buffer for the multi-cycle CPU: samples PC plus NUM_CH

---
 rtl/trace_capture_unit.sv | 178 +++++++++++++++++
 tb/tb_trace_capture_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_unit.sv
// trace_capture_unit
//   Triggered trace buffer. Each clock it can record {pc_in, ch_in, cycle stamp}
//   into a DEPTH-entry first-word-fall-through FIFO. Recording starts when the
//   selected trigger fires while armed and runs for a latched number of samples.
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   pc_in, ch_in       sampled PC and NUM_CH packed channels (ch k at [k*DATA_W +: DATA_W])
//   arm, abort         arm the trigger / return to IDLE (pulses)
//   trig_mode          0 immediate, 1 pc_in==trig_pc, 2 ch[trig_sel]==trig_val, 3 never
//   trig_pc, trig_sel, trig_val  live trigger operands
//   cap_len            samples per capture, latched at arm (0 or >DEPTH -> DEPTH)
//   rd_ready           consumer pops the head entry when rd_valid
//   rd_valid, rd_pc, rd_data, rd_cycle  head entry (zero while empty)
//   state              0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   overflow           sticky dropped-sample flag, cleared on arm
//   level              FIFO occupancy 0..DEPTH
module trace_capture_unit #(
  parameter int PC_W   = 13,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 6,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [NUM_CH*DATA_W-1:0] ch_in,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [1:0]               trig_mode,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic [SEL_W-1:0]         trig_sel,
  input  logic [DATA_W-1:0]        trig_val,
  input  logic [CNT_W-1:0]         cap_len,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [1:0]               state,
  output logic                     overflow,
  output logic [CNT_W-1:0]         level
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = PC_W + NUM_CH*DATA_W + CYC_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  logic [CYC_W-1:0]   cyc_cnt;
  logic [CNT_W-1:0]   cap_cnt;
  logic [CNT_W-1:0]   cap_len_q;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;

  logic [DATA_W-1:0]  sel_ch;
  logic               sel_ok;
  logic               trig_hit;
  logic               wr_en;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;
  logic [CNT_W-1:0]   len_sel;
  logic [CNT_W-1:0]   cnt_nxt;

  // Trigger evaluation on the current-cycle inputs; an out-of-range channel never matches.
  always_comb begin
    sel_ch = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig_sel == SEL_W'(k)) begin
        sel_ch = ch_in[k*DATA_W +: DATA_W];
        sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    case (trig_mode)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = (pc_in == trig_pc);
      2'd2:    trig_hit = sel_ok && (sel_ch == trig_val);
      default: trig_hit = 1'b0;
    endcase
  end

  assign len_sel = ((cap_len == '0) || (cap_len > FULL_LVL)) ? FULL_LVL : cap_len;
  assign cnt_nxt = cap_cnt + CNT_W'(1);

  assign full     = (level == FULL_LVL);
  assign rd_valid = (level != '0);
  assign pop      = rd_valid && rd_ready;
  assign wr_en    = !abort && (((state == S_ARMED) && trig_hit) || (state == S_CAPTURE));
  // A pop on the same edge frees the slot, so a full FIFO still accepts the sample.
  assign push     = wr_en && (!full || pop);
  assign drop     = wr_en && full && !pop;

  // Control: FSM, cycle stamp, capture counter, sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cyc_cnt   <= '0;
      cap_cnt   <= '0;
      cap_len_q <= '0;
      overflow  <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + CYC_W'(1);
      if (drop)
        overflow <= 1'b1;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm) begin
              state     <= S_ARMED;
              overflow  <= 1'b0;
              cap_cnt   <= '0;
              cap_len_q <= len_sel;
            end
          end
          S_ARMED: begin
            if (trig_hit) begin
              cap_cnt <= CNT_W'(1);
              state   <= (cap_len_q == CNT_W'(1)) ? S_DONE : S_CAPTURE;
            end
          end
          default: begin
            cap_cnt <= cnt_nxt;
            if (cnt_nxt == cap_len_q)
              state <= S_DONE;
          end
        endcase
      end
    end
  end

  // FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sample storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {pc_in, ch_in, cyc_cnt};
  end

  assign head     = mem[rd_ptr];
  assign rd_pc    = rd_valid ? head[ENTRY_W-1 -: PC_W]                 : '0;
  assign rd_data  = rd_valid ? head[CYC_W +: NUM_CH*DATA_W]            : '0;
  assign rd_cycle = rd_valid ? head[CYC_W-1:0]                         : '0;

endmodule

// File: tb/tb_trace_capture_unit.sv
module tb_trace_capture_unit;
  localparam int PC_W   = 13;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 6;
  localparam int DEPTH  = 16;
  localparam int CYC_W  = 16;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [PC_W-1:0]          pc_in;
  logic [NUM_CH*DATA_W-1:0] ch_in;
  logic                     arm, abort;
  logic [1:0]               trig_mode;
  logic [PC_W-1:0]          trig_pc;
  logic [SEL_W-1:0]         trig_sel;
  logic [DATA_W-1:0]        trig_val;
  logic [CNT_W-1:0]         cap_len;
  logic                     rd_ready;
  logic                     rd_valid;
  logic [PC_W-1:0]          rd_pc;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [CYC_W-1:0]         rd_cycle;
  logic [1:0]               state;
  logic                     overflow;
  logic [CNT_W-1:0]         level;

  trace_capture_unit dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .ch_in(ch_in), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_sel(trig_sel), .trig_val(trig_val),
    .cap_len(cap_len), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_data(rd_data), .rd_cycle(rd_cycle), .state(state), .overflow(overflow),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]          pc;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [CYC_W-1:0]         cyc;
  } entry_t;

  // Reference model: a queue of captured samples plus the capture bookkeeping.
  entry_t m_q[$];
  int     m_st, m_cnt, m_len, m_cyc;
  bit     m_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_st = 0; m_cnt = 0; m_len = 0; m_cyc = 0; m_ovf = 0;
  endtask

  function automatic bit model_trig();
    int s;
    case (trig_mode)
      2'd0: return 1'b1;
      2'd1: return pc_in == trig_pc;
      2'd2: begin
        s = int'(trig_sel);
        if (s >= NUM_CH) return 1'b0;
        return ch_in[s*DATA_W +: DATA_W] == trig_val;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs that were stable before it.
  task automatic model_update();
    bit     was_full, do_pop, do_wr, trg;
    entry_t e;
    trg      = model_trig();
    was_full = (m_q.size() == DEPTH);
    do_pop   = (m_q.size() > 0) && rd_ready;
    do_wr    = !abort && ((m_st == 1 && trg) || m_st == 2);
    if (do_pop) void'(m_q.pop_front());
    if (do_wr) begin
      e.pc = pc_in; e.data = ch_in; e.cyc = CYC_W'(m_cyc);
      if (!was_full || do_pop) m_q.push_back(e);
      else m_ovf = 1;
    end
    if (abort) m_st = 0;
    else begin
      case (m_st)
        0, 3: if (arm) begin
          m_st = 1; m_ovf = 0; m_cnt = 0;
          m_len = (cap_len == 0 || int'(cap_len) > DEPTH) ? DEPTH : int'(cap_len);
        end
        1: if (trg) begin
          m_cnt = 1;
          m_st  = (m_len == 1) ? 3 : 2;
        end
        default: begin
          m_cnt++;
          if (m_cnt == m_len) m_st = 3;
        end
      endcase
    end
    m_cyc = (m_cyc + 1) % (1 << CYC_W);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    entry_t h;
    h = '0;
    if (m_q.size() > 0) h = m_q[0];
    chk("rd_valid", 128'(rd_valid), 128'(m_q.size() > 0));
    chk("level",    128'(level),    128'(m_q.size()));
    chk("state",    128'(state),    128'(m_st));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("rd_pc",    128'(rd_pc),    128'(h.pc));
    chk("rd_data",  128'(rd_data),  128'(h.data));
    chk("rd_cycle", 128'(rd_cycle), 128'(h.cyc));
  end

  task automatic quiet();
    arm = 0; abort = 0; rd_ready = 0;
  endtask

  task automatic drain();
    quiet();
    rd_ready = 1;
    for (int i = 0; i < 40 && m_q.size() > 0; i++) tick();
    chk("drain_empty", 128'(level), 128'(0));
    rd_ready = 0;
  endtask

  task automatic arm_cap(input logic [1:0] mode, input logic [CNT_W-1:0] len);
    trig_mode = mode; cap_len = len; arm = 1;
    tick();
    arm = 0;
  endtask

  initial begin
    rst = 1; pc_in = 0; ch_in = '0; trig_mode = 0; trig_pc = 0; trig_sel = 0;
    trig_val = 0; cap_len = 0;
    quiet();
    model_reset();
    #1;
    chk("reset_state", 128'(state), 128'(0));
    chk("reset_valid", 128'(rd_valid), 128'(0));
    tick(); tick();
    rst = 0;
    tick();

    // T1 immediate capture of four samples
    arm_cap(2'd0, 5'd4);
    for (int i = 0; i < 4; i++) begin pc_in = PC_W'(10 + i); tick(); end
    chk("t1_state", 128'(state), 128'(3));
    chk("t1_level", 128'(level), 128'(4));
    chk("t1_ovf",   128'(overflow), 128'(0));
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin chk("t1_pc", 128'(rd_pc), 128'(10 + i)); tick(); end
    rd_ready = 0;

    // T2 PC trigger
    drain();
    trig_pc = 7; pc_in = 100;
    arm_cap(2'd1, 5'd3);
    for (int p = 0; p < 15; p++) begin pc_in = PC_W'(p); tick(); end
    chk("t2_level", 128'(level), 128'(3));
    rd_ready = 1;
    for (int i = 0; i < 3; i++) begin chk("t2_pc", 128'(rd_pc), 128'(7 + i)); tick(); end
    rd_ready = 0;

    // T3 channel trigger on channel 4
    drain();
    trig_sel = 4; trig_val = 42; ch_in = '0;
    arm_cap(2'd2, 5'd2);
    for (int i = 0; i < 10; i++) begin ch_in[4*DATA_W +: DATA_W] = DATA_W'(i); tick(); end
    chk("t3_armed", 128'(state), 128'(1));
    ch_in[4*DATA_W +: DATA_W] = 42; tick();
    ch_in[4*DATA_W +: DATA_W] = 0;  tick();
    chk("t3_level", 128'(level), 128'(2));
    chk("t3_ch4",   128'(rd_data[4*DATA_W +: DATA_W]), 128'(42));

    // T4 overflow into a full FIFO
    drain();
    arm_cap(2'd0, 5'd0);
    for (int i = 0; i < 18; i++) begin pc_in = PC_W'(200 + i); tick(); end
    chk("t4_full", 128'(level), 128'(16));
    arm_cap(2'd0, 5'd4);
    for (int i = 0; i < 4; i++) begin pc_in = PC_W'(300 + i); tick(); end
    chk("t4_ovf",   128'(overflow), 128'(1));
    chk("t4_level", 128'(level), 128'(16));
    chk("t4_state", 128'(state), 128'(3));
    chk("t4_head",  128'(rd_pc), 128'(200));

    // T5 push and pop together while full
    arm_cap(2'd0, 5'd4);
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin pc_in = PC_W'(400 + i); tick(); end
    rd_ready = 0;
    chk("t5_level", 128'(level), 128'(16));
    chk("t5_ovf",   128'(overflow), 128'(0));
    chk("t5_head",  128'(rd_pc), 128'(204));

    // T6 async reset mid-capture, then abort while armed
    drain();
    arm_cap(2'd0, 5'd0);
    tick(); tick();
    rst = 1;
    #1;
    chk("t6_rst_state", 128'(state), 128'(0));
    chk("t6_rst_valid", 128'(rd_valid), 128'(0));
    chk("t6_rst_level", 128'(level), 128'(0));
    chk("t6_rst_pc",    128'(rd_pc), 128'(0));
    model_reset();
    tick();
    rst = 0;
    arm_cap(2'd0, 5'd3);
    for (int i = 0; i < 4; i++) tick();
    arm_cap(2'd3, 5'd3);
    chk("t6_armed", 128'(state), 128'(1));
    abort = 1; tick(); abort = 0;
    chk("t6_abort_state", 128'(state), 128'(0));
    chk("t6_abort_level", 128'(level), 128'(3));

    // Randomised phase
    for (int i = 0; i < 4000; i++) begin
      int rd_bias;
      rd_bias = (i / 500) % 4;
      arm       = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 59) == 0);
      trig_mode = 2'($urandom_range(0, 3));
      trig_pc   = PC_W'($urandom_range(0, 7));
      pc_in     = PC_W'($urandom_range(0, 7));
      trig_sel  = SEL_W'($urandom_range(0, 7));
      trig_val  = DATA_W'($urandom_range(0, 3));
      for (int k = 0; k < NUM_CH; k++) ch_in[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 3));
      cap_len   = CNT_W'($urandom_range(0, 31));
      rd_ready  = ($urandom_range(0, 3) < rd_bias);
      if ($urandom_range(0, 699) == 0) begin
        rst = 1; #1; model_reset(); tick(); rst = 0;
      end else begin
        tick();
      end
    end

    quiet();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
